// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg: shared FSM state type and default widths for the MAC sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

    localparam int MAC_DATA_W = 16;
    localparam int MAC_ACC_W  = 32;
    localparam int MAC_ADDR_W = 8;
    localparam int MAC_LEN_W  = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_seq_addr_gen.sv
// ---------------------------------------------------------------------------
// mac_seq_addr_gen: element counter and wrapping A/B operand address generator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_seq_addr_gen
    import mac_pkg::*;
#(
    parameter int ADDR_W = MAC_ADDR_W,
    parameter int LEN_W  = MAC_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              last
);

    logic [LEN_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= '0;
        end else if (step) begin
            idx <= idx + LEN_W'(1);
        end
    end

    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap for free.
    assign addr_a = base_a + ADDR_W'(idx);
    assign addr_b = base_b + ADDR_W'(idx);
    assign last   = (idx == len - LEN_W'(1));

endmodule

`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl: dot-product sequencer feeding an external MAC from a buffer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int ADDR_W = MAC_ADDR_W,
    parameter int LEN_W  = MAC_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base_a,
    input  logic [ADDR_W-1:0] cmd_base_b,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    input  logic [DATA_W-1:0] mem_rd_data_a,
    input  logic [DATA_W-1:0] mem_rd_data_b,
    output logic              mac_clr,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid_in,
    input  logic [ACC_W-1:0]  mac_result,
    input  logic              mac_valid_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  done_cnt;
    logic              rd_en_d;
    logic [ACC_W-1:0]  res_q;

    logic              ready_c;
    logic              rd_en_c;
    logic              clr_c;
    logic              res_valid_c;
    logic              done_hit;
    logic              last;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;

    mac_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (clr_c),
        .step   (rd_en_c),
        .base_a (base_a),
        .base_b (base_b),
        .len    (len),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .last   (last)
    );

    // Final product lands when this pulse brings the count up to len.
    assign done_hit = mac_valid_out && ((done_cnt + LEN_W'(1)) == len);

    always_comb begin
        state_next  = state;
        ready_c     = 1'b0;
        rd_en_c     = 1'b0;
        clr_c       = 1'b0;
        res_valid_c = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                clr_c      = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                rd_en_c = 1'b1;
                if (last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (done_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid_c = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base_a   <= '0;
            base_b   <= '0;
            len      <= '0;
            done_cnt <= '0;
            rd_en_d  <= 1'b0;
            res_q    <= '0;
        end else begin
            state   <= state_next;
            rd_en_d <= rd_en_c;
            if (state == IDLE && cmd_valid) begin
                base_a <= cmd_base_a;
                base_b <= cmd_base_b;
                len    <= cmd_len;
                if (cmd_len == '0) begin
                    res_q <= '0;
                end
            end
            if (state == CLEAR) begin
                done_cnt <= '0;
            end else if ((state == ISSUE || state == DRAIN) && mac_valid_out) begin
                done_cnt <= done_cnt + LEN_W'(1);
            end
            if (state == DRAIN && done_hit) begin
                res_q <= mac_result;
            end
        end
    end

    // Outputs are forced quiet combinationally for as long as reset is held.
    assign cmd_ready    = ready_c & ~reset;
    assign mem_rd_en    = rd_en_c & ~reset;
    assign mem_addr_a   = mem_rd_en ? addr_a : '0;
    assign mem_addr_b   = mem_rd_en ? addr_b : '0;
    assign mac_clr      = clr_c & ~reset;
    assign mac_valid_in = rd_en_d & ~reset;
    assign mac_a        = mac_valid_in ? mem_rd_data_a : '0;
    assign mac_b        = mac_valid_in ? mem_rd_data_b : '0;
    assign res_valid    = res_valid_c & ~reset;
    assign res_data     = reset ? '0 : res_q;
    assign busy         = (state != IDLE) & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl: directed self-checking bench with buffer and MAC models.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mac_seq_ctrl;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base_a;
    logic [ADDR_W-1:0] cmd_base_b;
    logic [LEN_W-1:0]  cmd_len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [DATA_W-1:0] mem_rd_data_a;
    logic [DATA_W-1:0] mem_rd_data_b;
    logic              mac_clr;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_valid_in;
    logic [ACC_W-1:0]  mac_result;
    logic              mac_valid_out;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              busy;

    always #5 clk = ~clk;

    mac_seq_ctrl #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base_a    (cmd_base_a),
        .cmd_base_b    (cmd_base_b),
        .cmd_len       (cmd_len),
        .mem_rd_en     (mem_rd_en),
        .mem_addr_a    (mem_addr_a),
        .mem_addr_b    (mem_addr_b),
        .mem_rd_data_a (mem_rd_data_a),
        .mem_rd_data_b (mem_rd_data_b),
        .mac_clr       (mac_clr),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_result    (mac_result),
        .mac_valid_out (mac_valid_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy)
    );

    // Operand buffer: one-cycle read latency.
    logic [DATA_W-1:0] mem_a [256];
    logic [DATA_W-1:0] mem_b [256];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data_a <= mem_a[mem_addr_a];
            mem_rd_data_b <= mem_b[mem_addr_b];
        end
    end

    // MAC model with selectable latency (1..4), cleared by reset or mac_clr.
    int               lat = 1;
    logic [ACC_W-1:0] acc;
    logic             vout;
    logic [3:0]       dv;
    logic [ACC_W-1:0] dp [4];

    assign mac_result    = acc;
    assign mac_valid_out = vout;

    always @(posedge clk) begin
        logic             iv;
        logic [ACC_W-1:0] ip;
        logic [ACC_W-1:0] prod;
        prod = ACC_W'(mac_a) * ACC_W'(mac_b);
        if (lat == 1) begin
            iv = mac_valid_in;
            ip = prod;
        end else begin
            iv = dv[lat-2];
            ip = dp[lat-2];
        end
        if (reset || mac_clr) begin
            acc  <= '0;
            vout <= 1'b0;
            dv   <= '0;
            for (int i = 0; i < 4; i++) dp[i] <= '0;
        end else begin
            dv    <= {dv[2:0], mac_valid_in};
            dp[0] <= prod;
            dp[1] <= dp[0];
            dp[2] <= dp[1];
            dp[3] <= dp[2];
            vout  <= iv;
            if (iv) acc <= acc + ip;
        end
    end

    // Activity monitor; counters only ever increase, tests use deltas.
    int               rd_cnt   = 0;
    int               clr_cnt  = 0;
    int               vin_cnt  = 0;
    int               vout_cnt = 0;
    int               rv_cnt   = 0;
    logic [ADDR_W-1:0] addr_q [$];

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_cnt++;
            addr_q.push_back(mem_addr_a);
        end
        if (mac_clr)       clr_cnt++;
        if (mac_valid_in)  vin_cnt++;
        if (mac_valid_out) vout_cnt++;
        if (res_valid)     rv_cnt++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] bb,
                            input logic [LEN_W-1:0] len);
        int t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_base_a = ba;
        cmd_base_b = bb;
        cmd_len    = len;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("res_valid_seen", res_valid, 1);
    endtask

    task automatic ack();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rd0, clr0, vin0, vout0, rv0, q0;
        logic [ACC_W-1:0] d0;
        logic stable, saw_ready;

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[8'h00] = 16'd4;  mem_a[8'h01] = 16'd5;  mem_a[8'h02] = 16'd6;
        mem_b[8'h10] = 16'd2;  mem_b[8'h11] = 16'd3;  mem_b[8'h12] = 16'd2;
        mem_a[8'hFE] = 16'd7;  mem_a[8'hFF] = 16'd8;
        mem_b[8'h40] = 16'd1;  mem_b[8'h41] = 16'd2;  mem_b[8'h42] = 16'd3;  mem_b[8'h43] = 16'd4;
        for (int i = 8'h20; i < 8'h28; i++) begin
            mem_a[i] = 16'd100;
            mem_b[i] = 16'd9;
        end

        reset = 1'b1; cmd_valid = 1'b0; cmd_base_a = '0; cmd_base_b = '0; cmd_len = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_res_data", res_data, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Basic dot product: 4*2 + 5*3 + 6*2 = 35
        rd0 = rd_cnt; clr0 = clr_cnt; vin0 = vin_cnt;
        send_cmd(8'h00, 8'h10, 9'd3);
        check("clear_busy", busy, 1);
        check("clear_mac_clr", mac_clr, 1);
        check("clear_cmd_ready", cmd_ready, 0);
        wait_res(cyc);
        check("basic_latency", cyc, 6);
        check("basic_result", res_data, 35);
        check("basic_rd_count", rd_cnt - rd0, 3);
        check("basic_clr_count", clr_cnt - clr0, 1);
        check("basic_vin_count", vin_cnt - vin0, 3);
        ack();
        check("basic_back_idle", cmd_ready, 1);

        // Zero-length job: no buffer or MAC activity, immediate zero result
        rd0 = rd_cnt; clr0 = clr_cnt; vin0 = vin_cnt;
        send_cmd(8'h00, 8'h10, 9'd0);
        wait_res(cyc);
        check("len0_within_2", (cyc <= 2), 1);
        check("len0_result", res_data, 0);
        check("len0_rd_count", rd_cnt - rd0, 0);
        check("len0_clr_count", clr_cnt - clr0, 0);
        check("len0_vin_count", vin_cnt - vin0, 0);
        ack();

        // Result held while res_ready is low; stray commands ignored
        send_cmd(8'h00, 8'h10, 9'd3);
        wait_res(cyc);
        d0 = res_data; stable = 1'b1; saw_ready = 1'b0; rd0 = rd_cnt;
        for (int i = 0; i < 20; i++) begin
            cmd_valid = i[0];
            cmd_len   = 9'd5;
            @(negedge clk);
            if (res_data !== d0 || res_valid !== 1'b1) stable = 1'b0;
            if (cmd_ready) saw_ready = 1'b1;
        end
        cmd_valid = 1'b0;
        check("hold_result", d0, 35);
        check("hold_stable", stable, 1);
        check("hold_cmd_ready_low", saw_ready, 0);
        check("hold_no_reads", rd_cnt - rd0, 0);
        ack();
        check("hold_released_idle", busy, 0);

        // Address wrap: A at FE,FF,00,01 = 7,8,4,5; B = 1,2,3,4 -> 55
        q0 = addr_q.size();
        send_cmd(8'hFE, 8'h40, 9'd4);
        wait_res(cyc);
        check("wrap_result", res_data, 55);
        check("wrap_rd_count", addr_q.size() - q0, 4);
        if (addr_q.size() - q0 == 4) begin
            check("wrap_addr0", addr_q[q0],   8'hFE);
            check("wrap_addr1", addr_q[q0+1], 8'hFF);
            check("wrap_addr2", addr_q[q0+2], 8'h00);
            check("wrap_addr3", addr_q[q0+3], 8'h01);
        end
        ack();

        // Reset during the second ISSUE cycle of a len=5 job
        send_cmd(8'h20, 8'h20, 9'd5);
        @(negedge clk);
        @(negedge clk);
        check("abort_issue2_rd_en", mem_rd_en, 1);
        check("abort_issue2_addr", mem_addr_a, 8'h21);
        reset = 1'b1;
        @(negedge clk);
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_mem_rd_en", mem_rd_en, 0);
        check("abort_mem_addr_a", mem_addr_a, 0);
        check("abort_mem_addr_b", mem_addr_b, 0);
        check("abort_mac_clr", mac_clr, 0);
        check("abort_mac_a", mac_a, 0);
        check("abort_mac_b", mac_b, 0);
        check("abort_mac_valid_in", mac_valid_in, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_res_data", res_data, 0);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        rv0 = rv_cnt;
        repeat (10) @(negedge clk);
        check("abort_no_result", rv_cnt - rv0, 0);
        check("abort_idle_ready", cmd_ready, 1);
        send_cmd(8'h00, 8'h10, 9'd3);
        wait_res(cyc);
        check("after_abort_result", res_data, 35);
        ack();

        // Three-cycle MAC: completion waits for the third valid_out pulse
        lat = 3;
        vout0 = vout_cnt;
        send_cmd(8'h00, 8'h10, 9'd3);
        wait_res(cyc);
        check("lat3_latency", cyc, 8);
        check("lat3_vout_count", vout_cnt - vout0, 3);
        check("lat3_result", res_data, 35);
        ack();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
